// File: rtl/z80mini_uart_pkg.sv
// +----------------------------------------------------------------------+
// | Package : z80mini_uart_pkg                                           |
// | Shared definitions for the z80mini hardware UART: register offsets,  |
// | STATUS bit positions, shifter state encoding, minimum divisor.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package z80mini_uart_pkg;

  // Register offsets within the 4-port window (A[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIVL   = 2'd2;
  localparam logic [1:0] REG_DIVH   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_NF   = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_RXOVR   = 3;
  localparam int ST_FERR    = 4;
  localparam int ST_TXOVR   = 5;
  localparam int ST_RXIE    = 6;
  localparam int ST_TXIE    = 7;

  // Smallest usable divisor; below this the mid-bit sampling has no margin
  localparam logic [15:0] MIN_DIV = 16'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | Module  : sync_fifo                                                  |
// | Single-clock FIFO, power-of-two depth, show-ahead head output.       |
// | Ports   : clk, rst (sync, active high), push/push_data, pop,         |
// |           head (oldest entry), full, empty.                          |
// | Push when full and pop when empty are ignored; push and pop in the   |
// | same clock both take effect.                                         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/z80_uart_fifo.sv
// +----------------------------------------------------------------------+
// | Module  : z80_uart_fifo                                              |
// | 8N1 UART on the Z80 I/O bus with RX/TX FIFOs, runtime 16-bit baud    |
// | divisor (bit = DIV+1 clocks, min 16) and sticky error flags.         |
// | Ports   : CLK50MHz, RESET (sync, active high), CPUCLK0 write strobe, |
// |           A/DI/nIORQ/nRD/nWR/nM1 bus inputs, DO/OE read data and     |
// |           drive enable, RXD serial in, TXD serial out, IRQ.          |
// | Option  : define Z80_UART_IRQ_EN for RXIE/TXIE (STATUS b6/b7) and a  |
// |           registered IRQ output; otherwise IRQ is tied low.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module z80_uart_fifo #(
  parameter logic [7:0]  BASE_PORT  = 8'hC0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic       CLK50MHz,
  input  logic       RESET,
  input  logic       CPUCLK0,
  input  logic [7:0] A,
  input  logic [7:0] DI,
  input  logic       nIORQ,
  input  logic       nRD,
  input  logic       nWR,
  input  logic       nM1,
  output logic [7:0] DO,
  output logic       OE,
  input  logic       RXD,
  output logic       TXD,
  output logic       IRQ
);
  import z80mini_uart_pkg::*;

  // ---------------- bus decode ----------------
  logic sel, rd_act, wr_act, wr_commit;
  logic wr_data, wr_status, wr_divl, wr_divh;
  logic rd_act_q, rd_hit_q, rd_hit_d, wr_done_q, wr_done_d;
  logic rx_pop, tx_push, tx_pop, rx_push;

  assign sel       = (A[7:2] == BASE_PORT[7:2]);
  assign rd_act    = sel & ~nIORQ & ~nRD & nM1;
  assign wr_act    = sel & ~nIORQ & ~nWR & nM1;
  // Only the first strobed clock of an I/O write commits
  assign wr_commit = wr_act & CPUCLK0 & ~wr_done_q;
  assign wr_done_d = wr_act & (wr_done_q | CPUCLK0);
  assign wr_data   = wr_commit & (A[1:0] == REG_DATA);
  assign wr_status = wr_commit & (A[1:0] == REG_STATUS);
  assign wr_divl   = wr_commit & (A[1:0] == REG_DIVL);
  assign wr_divh   = wr_commit & (A[1:0] == REG_DIVH);

  // Remember whether the read in progress actually saw an RX byte, so the
  // pop after rd_act falls never consumes a byte the CPU did not get.
  assign rd_hit_d = rd_act & (A[1:0] == REG_DATA) & ~rx_empty;
  assign rx_pop   = rd_act_q & ~rd_act & rd_hit_q;

  // ---------------- FIFOs ----------------
  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;

  assign tx_push = wr_data & ~tx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK50MHz), .rst(RESET), .push(tx_push), .push_data(DI),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  logic [7:0] rx_sh_q, rx_sh_d;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK50MHz), .rst(RESET), .push(rx_push), .push_data(rx_sh_q),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- divisor ----------------
  logic [15:0] div_q, div_d, div_eff;

  always_comb begin
    div_d = div_q;
    if (wr_divl) div_d[7:0]  = DI;
    if (wr_divh) div_d[15:8] = DI;
  end
  // Sampled only at counter reloads, so a mid-bit change lands on the next bit
  assign div_eff = eff_div(div_q);

  // ---------------- TX shifter ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; tx_cnt_d = div_eff; tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_eff; tx_bit_d = 3'd0; tx_state_d = S_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_eff;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: begin  // S_STOP: reload straight from the FIFO for back-to-back frames
        if (tx_cnt_q == 16'd0) begin
          if (!tx_empty) begin
            tx_pop = 1'b1; tx_sh_d = tx_head; tx_cnt_d = div_eff; tx_state_d = S_START;
          end else tx_state_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
    endcase
    // Registered line output, decoded from the next state
    txd_d = (tx_state_d == S_START) ? 1'b0 :
            (tx_state_d == S_DATA)  ? tx_sh_d[0] : 1'b1;
  end

  // ---------------- RX sampler ----------------
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        ferr_set, rxovr_set;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    rxovr_set  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d = {1'b0, div_eff[15:1]};  // half a bit to reach mid-start
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) rx_state_d = S_IDLE;  // glitch, not a start bit
          else begin
            rx_cnt_d = div_eff; rx_bit_d = 3'd0; rx_state_d = S_DATA;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_eff;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: begin  // S_STOP
        if (rx_cnt_q == 16'd0) begin
          if (!rx_s2_q)     ferr_set  = 1'b1;
          else if (rx_full) rxovr_set = 1'b1;
          else              rx_push   = 1'b1;
          rx_state_d = S_IDLE;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
    endcase
  end

  // ---------------- sticky flags (set beats clear) ----------------
  logic rxovr_q, rxovr_d, ferr_q, ferr_d, txovr_q, txovr_d;

  assign rxovr_d = (rxovr_q & ~wr_status) | rxovr_set;
  assign ferr_d  = (ferr_q  & ~wr_status) | ferr_set;
  assign txovr_d = (txovr_q & ~wr_status) | (wr_data & tx_full);

  // ---------------- optional interrupt ----------------
  logic [1:0] ie_bits;
`ifdef Z80_UART_IRQ_EN
  logic rxie_q, rxie_d, txie_q, txie_d, irq_q, irq_d;
  assign rxie_d  = wr_status ? DI[ST_RXIE] : rxie_q;
  assign txie_d  = wr_status ? DI[ST_TXIE] : txie_q;
  assign irq_d   = (rxie_q & ~rx_empty) | (txie_q & tx_empty);
  assign ie_bits = {txie_q, rxie_q};
  assign IRQ     = irq_q;
  always_ff @(posedge CLK50MHz) begin
    if (RESET) begin
      rxie_q <= 1'b0; txie_q <= 1'b0; irq_q <= 1'b0;
    end else begin
      rxie_q <= rxie_d; txie_q <= txie_d; irq_q <= irq_d;
    end
  end
`else
  assign ie_bits = 2'b00;
  assign IRQ     = 1'b0;
`endif

  // ---------------- state registers ----------------
  always_ff @(posedge CLK50MHz) begin
    if (RESET) begin
      rd_act_q   <= 1'b0;  rd_hit_q  <= 1'b0;  wr_done_q <= 1'b0;
      div_q      <= DIV_RESET;
      tx_state_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      rx_s1_q    <= 1'b1;  rx_s2_q   <= 1'b1;  rx_prev_q <= 1'b1;
      rxovr_q    <= 1'b0;  ferr_q    <= 1'b0;  txovr_q   <= 1'b0;
    end else begin
      rd_act_q   <= rd_act; rd_hit_q <= rd_hit_d; wr_done_q <= wr_done_d;
      div_q      <= div_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      rx_s1_q    <= RXD;   rx_s2_q   <= rx_s1_q; rx_prev_q <= rx_s2_q;
      rxovr_q    <= rxovr_d; ferr_q  <= ferr_d;  txovr_q   <= txovr_d;
    end
  end

  // ---------------- read path ----------------
  logic [7:0] status;

  always_comb begin
    status             = 8'h00;
    status[ST_RX_NE]   = ~rx_empty;
    status[ST_TX_NF]   = ~tx_full;
    status[ST_TX_IDLE] = tx_empty & (tx_state_q == S_IDLE);
    status[ST_RXOVR]   = rxovr_q;
    status[ST_FERR]    = ferr_q;
    status[ST_TXOVR]   = txovr_q;
    status[ST_RXIE]    = ie_bits[0];
    status[ST_TXIE]    = ie_bits[1];
  end

  always_comb begin
    DO = 8'hFF;
    if (sel) begin
      case (A[1:0])
        REG_DATA:   DO = rx_empty ? 8'hFF : rx_head;
        REG_STATUS: DO = status;
        REG_DIVL:   DO = div_q[7:0];
        default:    DO = div_q[15:8];
      endcase
    end
  end

  assign OE  = rd_act;
  assign TXD = txd_q;

endmodule

`default_nettype wire

// File: doc/z80_uart_fifo.md
Name: z80_uart_fifo

Overview:
- Hardware UART on the Z80 I/O bus for the z80mini board; replaces the bit-banged soft UART on EXT_P[2]/EXT_P[3].
- 8N1 framing, runtime 16-bit baud divisor, parametrised-depth RX and TX FIFOs, sticky error flags.
- Runs entirely on CLK50MHz; qualifies CPU writes with the CPUCLK0 strobe, like the existing mapper.
- Top level owns the D tristate: D = OE ? DO : Z.

Parameters:
- BASE_PORT, 8'hC0: I/O base; block is selected when A[7:2] == BASE_PORT[7:2].
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..256.
- DIV_RESET, 16'd433: reset divisor; bit period is DIV+1 clocks (115200 baud at 50 MHz).

Ports:
- CLK50MHz  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CPUCLK0  in  1  one-cycle strobe per CPU clock; write qualifier.
- A  in  8  CPU address A[7:0].
- DI  in  8  CPU data in.
- nIORQ, nRD, nWR, nM1  in  1 each  Z80 bus controls.
- DO  out  8  read data.
- OE  out  1  drive D with DO.
- RXD  in  1  serial in, asynchronous.
- TXD  out  1  serial out, idle high.
- IRQ  out  1  active-high interrupt request.

Behaviour:
- Select and access terms:
  - sel = A[7:2] == BASE_PORT[7:2].
  - rd_act = sel & ~nIORQ & ~nRD & nM1.
  - wr_act = sel & ~nIORQ & ~nWR & nM1.
  - INT-ack cycles (nM1 = 0) are never accesses.
- OE = rd_act, combinational. DO is combinational from A[1:0] and is 8'hFF when not selected.
- Write commit: exactly once per I/O cycle, on the first clock with wr_act & CPUCLK0. Further commits are blocked until wr_act drops.
- Read side effect (RX pop): once per I/O cycle, on the clock after rd_act falls (registered edge). DO stays stable for the whole read.
- Register map, offset A[1:0]:
  - 0 DATA. Read returns the RX head, or 8'hFF with no pop if RX is empty. Write pushes to TX; if TX is full the byte is dropped and TXOVR is set.
  - 1 STATUS (read):
    - b0 RX not empty.
    - b1 TX not full.
    - b2 TX idle (FIFO empty and shifter idle).
    - b3 RXOVR, sticky.
    - b4 FERR, sticky.
    - b5 TXOVR, sticky.
    - b7:6 see Optional Feature.
  - 1 STATUS (write): clears b3..b5, whatever the data.
  - 2 DIVL: divisor[7:0], R/W.
  - 3 DIVH: divisor[15:8], R/W.
  - Effective divisor is max(DIV, 15).
- Divisor change mid-frame: the new value applies from the next bit-counter reload; the current bit completes with the old value.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: TXD = 1. If TX FIFO is not empty, pop and go to START on the next clock.
  - START: TXD = 0.
  - DATA: 8 bits, LSB first.
  - STOP: TXD = 1.
  - Each state lasts DIV+1 clocks.
  - From STOP, reload directly from the FIFO when not empty, so frames go back-to-back with no extra idle bit.
- RX FSM (IDLE, START, DATA, STOP):
  - RXD passes through a 2-flop synchroniser.
  - IDLE: wait for a 1→0 transition.
  - START: sample at (DIV+1)/2 clocks. If high, false start, return to IDLE.
  - DATA: sample each bit mid-period, LSB first.
  - STOP: sample mid-period. If 0, set FERR and discard the byte. If 1 and RX is full, set RXOVR and drop the byte. Otherwise push.
  - Then return to IDLE.
- Simultaneous events:
  - RX push and CPU pop in the same clock: both occur; count unchanged.
  - TX push and shifter pop in the same clock: both occur.
  - Sticky-set and STATUS-write clear in the same clock: set wins.
- Reset (also mid-frame):
  - Both FIFOs empty, both FSMs IDLE.
  - TXD = 1, IRQ = 0, sticky flags 0, DIV = DIV_RESET, IE bits 0.
  - Any frame in progress is abandoned.

Optional Feature:
- Macro Z80_UART_IRQ_EN.
- Defined:
  - A STATUS write also loads b6 = RXIE and b7 = TXIE; STATUS read returns them in b7:6.
  - IRQ = (RXIE & RX not empty) | (TXIE & TX FIFO empty), registered, 1-clock latency.
  - The top level wires IRQ into the nINT open-drain term and supplies the IM2 vector.
- Undefined: IRQ is tied 0, STATUS b7:6 read 0, and writes to them are ignored.

Decomposition:
- Package z80mini_uart_pkg:
  - register offsets REG_DATA/REG_STATUS/REG_DIVL/REG_DIVH;
  - STATUS bit indices;
  - TX/RX state enum;
  - MIN_DIV = 15.
- Sub-module sync_fifo: parameter WIDTH = 8, DEPTH; single-clock FIFO with push/pop/full/empty and head data; instantiated twice.

Test Plan:
- Reset, then read ports C0..C3 → FF, 06, B1, 01; TXD = 1; IRQ = 0.
- Write DIV = 0x0013 (20-clock bit), write DATA 0x55 → TXD start bit at clock 1 after commit, bits 1,0,1,0,1,0,1,0 each 20 clocks, stop high; STATUS b2 returns to 1 after 200 clocks.
- Drive RXD frame 0xA3 at DIV+1 = 20 clocks/bit → STATUS b0 = 1; DATA read returns A3, pops exactly once across a 3-CPU-clock read; next STATUS b0 = 0.
- Push 17 bytes into TX (FIFO_DEPTH 16) while the shifter is busy → the 17th is dropped, TXOVR set; STATUS write clears it; 16 frames are transmitted back-to-back.
- RX frame with stop bit 0 → FERR set, RX empty. 17 good frames with no reads → RXOVR set, 16 bytes retained in order. Glitch on RXD shorter than half a bit → no byte.
- With Z80_UART_IRQ_EN: STATUS write 0x40, receive a byte → IRQ high 1 clock after push, low 1 clock after pop. Assert RESET mid-TX-frame → TXD = 1 and FIFOs empty on the next clock.
